// File: rtl/count_cycle_gen.sv
// Tags each accepted AXI-Stream sample with its index inside a cnt_limit-defined cycle
// and a final-sample flag, then queues {tlast, count, data} in an output FIFO.
module count_cycle_gen #(
    parameter int DATA_WIDTH      = 32,
    parameter int CNT_WIDTH       = 16,
    parameter int FIFO_ADDR_WIDTH = 5,
    parameter int AF_THRESH       = 16,
    parameter int ONE_SHOT        = 0
) (
    input  logic                  clk,
    input  logic                  sync_reset,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    output logic                  s_axis_tready,
    input  logic [CNT_WIDTH-1:0]  cnt_limit,
    input  logic                  start_sig,
    output logic                  af,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [CNT_WIDTH-1:0]  m_axis_count,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready
);

    localparam int OCC_W = FIFO_ADDR_WIDTH + 1;
    localparam int ENT_W = DATA_WIDTH + CNT_WIDTH + 1;
    localparam int DEPTH = 2 ** FIFO_ADDR_WIDTH;
    localparam logic [OCC_W:0]           DEPTH_P  = {2'b01, {FIFO_ADDR_WIDTH{1'b0}}};
    localparam logic [OCC_W-1:0]         AF_P     = OCC_W'(AF_THRESH);
    localparam logic [OCC_W-1:0]         OCC_ONE  = {{(OCC_W-1){1'b0}}, 1'b1};
    localparam logic [FIFO_ADDR_WIDTH-1:0] PTR_ONE = {{(FIFO_ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]     CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam bit                       ONE_SHOT_EN = (ONE_SHOT != 32'sd0);

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALT    = 2'd2
    } state_t;

    state_t                     state_r, state_next_s;
    logic [CNT_WIDTH-1:0]       prev_cnt_r, lim_r, cnt_s, lim_eff_s;
    logic                       zero_s, gate_s, last_s, take_s, tready_s, space_ok_s;
    logic [OCC_W:0]             pending_s;
    logic                       s1_valid_r, s2_valid_r;
    logic [ENT_W-1:0]           s1_ent_r, s2_ent_r, rd_ent_s;
    logic [ENT_W-1:0]           mem_r [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_r, rd_ptr_r;
    logic [OCC_W-1:0]           occ_r, occ_next_s;
    logic                       af_r, tvalid_r, push_s, pop_s;

    // In-flight pipeline entries count against capacity so the FIFO can never overflow.
    assign pending_s  = {1'b0, occ_r} + {{OCC_W{1'b0}}, s1_valid_r} + {{OCC_W{1'b0}}, s2_valid_r};
    assign space_ok_s = (pending_s < DEPTH_P);

    // Acceptance gating, count assignment, final-sample flag and next state
    always_comb begin
        zero_s = 1'b1;
        gate_s = 1'b0;
        case (state_r)
            ST_STARTUP: begin zero_s = 1'b1; gate_s = 1'b1; end
            ST_RUN:     begin zero_s = start_sig | (prev_cnt_r == lim_r); gate_s = 1'b1; end
            ST_HALT:    begin zero_s = 1'b1; gate_s = start_sig; end
            default:    begin zero_s = 1'b1; gate_s = 1'b1; end
        endcase
        tready_s = gate_s & space_ok_s & ~sync_reset;
        take_s   = s_axis_tvalid & tready_s;
        // A count-0 sample opens a new cycle and samples the limit it will run against.
        if (zero_s) begin
            cnt_s     = '0;
            lim_eff_s = cnt_limit;
        end else begin
            cnt_s     = prev_cnt_r + CNT_ONE;
            lim_eff_s = lim_r;
        end
        last_s = (cnt_s == lim_eff_s);
        if (take_s) begin
            if (ONE_SHOT_EN && last_s) begin
                state_next_s = ST_HALT;
            end else begin
                state_next_s = ST_RUN;
            end
        end else begin
            state_next_s = state_r;
        end
    end

    // State, last issued count and the limit held for the current cycle
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_r    <= ST_STARTUP;
            prev_cnt_r <= '0;
            lim_r      <= '0;
        end else begin
            state_r <= state_next_s;
            if (take_s) begin
                prev_cnt_r <= cnt_s;
                lim_r      <= lim_eff_s;
            end
        end
    end

    // Two-stage delay line carrying tagged samples toward the FIFO
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
            s1_ent_r   <= '0;
            s2_ent_r   <= '0;
        end else begin
            s1_valid_r <= take_s;
            s2_valid_r <= s1_valid_r;
            s1_ent_r   <= {last_s, cnt_s, s_axis_tdata};
            s2_ent_r   <= s1_ent_r;
        end
    end

    assign push_s = s2_valid_r;
    assign pop_s  = tvalid_r & m_axis_tready;

    // Occupancy after this cycle's push/pop
    always_comb begin
        occ_next_s = occ_r;
        case ({push_s, pop_s})
            2'b10:   occ_next_s = occ_r + OCC_ONE;
            2'b01:   occ_next_s = occ_r - OCC_ONE;
            default: occ_next_s = occ_r;
        endcase
    end

    // FIFO pointers, occupancy, output valid and almost-full flag
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            occ_r    <= '0;
            tvalid_r <= 1'b0;
            af_r     <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            occ_r    <= occ_next_s;
            tvalid_r <= (occ_next_s != '0);
            af_r     <= (occ_next_s >= AF_P);
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (push_s && !sync_reset) begin
            mem_r[wr_ptr_r] <= s2_ent_r;
        end
    end

    assign rd_ent_s      = mem_r[rd_ptr_r];
    assign s_axis_tready = tready_s;
    assign af            = af_r;
    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tdata  = rd_ent_s[DATA_WIDTH-1:0];
    assign m_axis_count  = rd_ent_s[DATA_WIDTH +: CNT_WIDTH];
    assign m_axis_tlast  = rd_ent_s[ENT_W-1];

endmodule

// File: tb/tb_count_cycle_gen.sv
// Directed bench: a default instance (16-bit count, free-running) and a 4-bit one-shot
// instance, each driven from vectors and checked against a queue of expected outputs.
module tb_count_cycle_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_tvalid, a_tready, a_start, a_af, a_mvalid, a_mlast, a_mready;
    logic [31:0] a_tdata, a_mdata;
    logic [15:0] a_limit, a_mcount;
    logic        b_rst, b_tvalid, b_tready, b_start, b_af, b_mvalid, b_mlast, b_mready;
    logic [31:0] b_tdata, b_mdata;
    logic [3:0]  b_limit, b_mcount;

    count_cycle_gen dut_a (
        .clk(clk), .sync_reset(a_rst), .s_axis_tvalid(a_tvalid), .s_axis_tdata(a_tdata),
        .s_axis_tready(a_tready), .cnt_limit(a_limit), .start_sig(a_start), .af(a_af),
        .m_axis_tvalid(a_mvalid), .m_axis_tdata(a_mdata), .m_axis_count(a_mcount),
        .m_axis_tlast(a_mlast), .m_axis_tready(a_mready));

    count_cycle_gen #(.CNT_WIDTH(4), .ONE_SHOT(1)) dut_b (
        .clk(clk), .sync_reset(b_rst), .s_axis_tvalid(b_tvalid), .s_axis_tdata(b_tdata),
        .s_axis_tready(b_tready), .cnt_limit(b_limit), .start_sig(b_start), .af(b_af),
        .m_axis_tvalid(b_mvalid), .m_axis_tdata(b_mdata), .m_axis_count(b_mcount),
        .m_axis_tlast(b_mlast), .m_axis_tready(b_mready));

    typedef struct {
        logic [31:0] data;
        logic [15:0] cnt;
        logic        last;
    } exp_t;

    typedef struct {
        logic        rst;
        int          gap;
        logic        idle_start;
        logic        start;
        logic [15:0] limit;
        logic [15:0] exp_cnt;
        logic        exp_last;
    } vec_t;

    exp_t a_q[$];
    exp_t b_q[$];
    vec_t vt[$];
    int   checks = 0;
    int   errors = 0;
    int   a_mode = 0;
    int   b_mode = 0;

    function automatic vec_t mk(input logic rst, input int gap, input logic istart,
                                input logic st, input logic [15:0] lim,
                                input logic [15:0] ec, input logic el);
        vec_t v;
        v.rst = rst; v.gap = gap; v.idle_start = istart; v.start = st;
        v.limit = lim; v.exp_cnt = ec; v.exp_last = el;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [31:0] d, input logic st, input logic [15:0] lim,
                          input logic [15:0] ec, input logic el);
        exp_t e;
        logic ok;
        a_tvalid = 1'b1; a_tdata = d; a_start = st; a_limit = lim; ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (a_tready) begin ok = 1'b1; break; end
        end
        chk("a_take", {31'd0, ok}, 32'd1);
        tick();
        if (ok) begin
            e.data = d; e.cnt = ec; e.last = el;
            a_q.push_back(e);
        end
    endtask

    task automatic send_b(input logic [31:0] d, input logic st, input logic [3:0] lim,
                          input logic [15:0] ec, input logic el);
        exp_t e;
        logic ok;
        b_tvalid = 1'b1; b_tdata = d; b_start = st; b_limit = lim; ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (b_tready) begin ok = 1'b1; break; end
        end
        chk("b_take", {31'd0, ok}, 32'd1);
        tick();
        if (ok) begin
            e.data = d; e.cnt = ec; e.last = el;
            b_q.push_back(e);
        end
    endtask

    task automatic reset_a();
        a_tvalid = 1'b0; a_start = 1'b0; a_rst = 1'b1;
        @(negedge clk);
        chk("a_tready_in_reset", {31'd0, a_tready}, 32'd0);
        tick();
        a_rst = 1'b0;
        a_q.delete();
        @(negedge clk);
        chk("a_rst_mvalid", {31'd0, a_mvalid}, 32'd0);
        chk("a_rst_af", {31'd0, a_af}, 32'd0);
        chk("a_rst_tready", {31'd0, a_tready}, 32'd1);
        tick();
    endtask

    task automatic reset_b();
        b_tvalid = 1'b0; b_start = 1'b0; b_rst = 1'b1;
        @(negedge clk);
        chk("b_tready_in_reset", {31'd0, b_tready}, 32'd0);
        tick();
        b_rst = 1'b0;
        b_q.delete();
        @(negedge clk);
        chk("b_rst_mvalid", {31'd0, b_mvalid}, 32'd0);
        chk("b_rst_af", {31'd0, b_af}, 32'd0);
        tick();
    endtask

    task automatic drain_a();
        for (int n = 0; n < 300; n++) begin
            if (a_q.size() == 0) break;
            @(negedge clk);
        end
        chk("a_drain", a_q.size(), 32'd0);
        tick();
    endtask

    task automatic drain_b();
        for (int n = 0; n < 300; n++) begin
            if (b_q.size() == 0) break;
            @(negedge clk);
        end
        chk("b_drain", b_q.size(), 32'd0);
        tick();
    endtask

    initial begin
        a_rst = 1'b1; a_tvalid = 1'b0; a_tdata = '0; a_start = 1'b0; a_limit = '0; a_mready = 1'b1;
        b_rst = 1'b1; b_tvalid = 1'b0; b_tdata = '0; b_start = 1'b0; b_limit = '0; b_mready = 1'b1;

        // Expected outputs, one record per sample
        for (int i = 0; i < 10; i++)
            vt.push_back(mk(i == 0, 0, 1'b0, 1'b0, 16'd3, 16'(i % 4), (i % 4) == 3));
        vt.push_back(mk(1'b1, 0, 1'b0, 1'b0, 16'd5, 16'd0, 1'b0));
        vt.push_back(mk(1'b0, 0, 1'b0, 1'b0, 16'd5, 16'd1, 1'b0));
        vt.push_back(mk(1'b0, 0, 1'b0, 1'b0, 16'd1, 16'd2, 1'b0));
        vt.push_back(mk(1'b0, 0, 1'b0, 1'b1, 16'd1, 16'd0, 1'b0));
        vt.push_back(mk(1'b0, 0, 1'b0, 1'b0, 16'd1, 16'd1, 1'b1));
        vt.push_back(mk(1'b0, 0, 1'b0, 1'b0, 16'd1, 16'd0, 1'b0));
        vt.push_back(mk(1'b0, 0, 1'b0, 1'b0, 16'd1, 16'd1, 1'b1));
        vt.push_back(mk(1'b1, 0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1));
        vt.push_back(mk(1'b0, 0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1));
        vt.push_back(mk(1'b0, 0, 1'b0, 1'b0, 16'd2, 16'd0, 1'b0));
        vt.push_back(mk(1'b0, 2, 1'b1, 1'b0, 16'd2, 16'd1, 1'b0));
        vt.push_back(mk(1'b0, 0, 1'b0, 1'b1, 16'd2, 16'd0, 1'b0));
        vt.push_back(mk(1'b0, 0, 1'b0, 1'b0, 16'd2, 16'd1, 1'b0));
        vt.push_back(mk(1'b0, 0, 1'b0, 1'b0, 16'd2, 16'd2, 1'b1));
        vt.push_back(mk(1'b0, 0, 1'b0, 1'b1, 16'd0, 16'd0, 1'b1));
        vt.push_back(mk(1'b0, 0, 1'b0, 1'b1, 16'd0, 16'd0, 1'b1));
        vt.push_back(mk(1'b0, 1, 1'b0, 1'b0, 16'd5, 16'd0, 1'b0));
        vt.push_back(mk(1'b0, 0, 1'b0, 1'b0, 16'd5, 16'd1, 1'b0));

        fork
            begin : ready_gen
                forever begin
                    @(posedge clk);
                    #1;
                    case (a_mode)
                        0:       a_mready = 1'b1;
                        1:       a_mready = 1'b0;
                        default: a_mready = 1'($urandom_range(0, 1));
                    endcase
                    case (b_mode)
                        0:       b_mready = 1'b1;
                        1:       b_mready = 1'b0;
                        default: b_mready = 1'($urandom_range(0, 1));
                    endcase
                end
            end
            begin : mon_a
                logic pv, plast;
                logic [31:0] pdata;
                logic [15:0] pcnt;
                exp_t e;
                pv = 1'b0; plast = 1'b0; pdata = '0; pcnt = '0;
                forever begin
                    @(negedge clk);
                    if (a_rst) begin
                        pv = 1'b0;
                    end else begin
                        if (pv) begin
                            chk("a_hold_valid", {31'd0, a_mvalid}, 32'd1);
                            chk("a_hold_data", a_mdata, pdata);
                            chk("a_hold_meta", {15'd0, a_mlast, a_mcount}, {15'd0, plast, pcnt});
                        end
                        if (a_mvalid && a_mready) begin
                            if (a_q.size() == 0) begin
                                checks++; errors++;
                                $display("FAIL a_unexpected: got data %0h, expected no output", a_mdata);
                            end else begin
                                e = a_q.pop_front();
                                chk("a_data", a_mdata, e.data);
                                chk("a_count", {16'd0, a_mcount}, {16'd0, e.cnt});
                                chk("a_tlast", {31'd0, a_mlast}, {31'd0, e.last});
                            end
                        end
                        pv = a_mvalid && !a_mready;
                        pdata = a_mdata; pcnt = a_mcount; plast = a_mlast;
                    end
                end
            end
            begin : mon_b
                logic pv, plast;
                logic [31:0] pdata;
                logic [3:0] pcnt;
                exp_t e;
                pv = 1'b0; plast = 1'b0; pdata = '0; pcnt = '0;
                forever begin
                    @(negedge clk);
                    if (b_rst) begin
                        pv = 1'b0;
                    end else begin
                        if (pv) begin
                            chk("b_hold_valid", {31'd0, b_mvalid}, 32'd1);
                            chk("b_hold_data", b_mdata, pdata);
                            chk("b_hold_meta", {27'd0, b_mlast, b_mcount}, {27'd0, plast, pcnt});
                        end
                        if (b_mvalid && b_mready) begin
                            if (b_q.size() == 0) begin
                                checks++; errors++;
                                $display("FAIL b_unexpected: got data %0h, expected no output", b_mdata);
                            end else begin
                                e = b_q.pop_front();
                                chk("b_data", b_mdata, e.data);
                                chk("b_count", {28'd0, b_mcount}, {28'd0, e.cnt[3:0]});
                                chk("b_tlast", {31'd0, b_mlast}, {31'd0, e.last});
                            end
                        end
                        pv = b_mvalid && !b_mready;
                        pdata = b_mdata; pcnt = b_mcount; plast = b_mlast;
                    end
                end
            end
            begin : watchdog
                #2000000;
                $display("FAIL watchdog: simulation still running, expected completion");
                $fatal(1);
            end
        join_none

        repeat (2) tick();

        // Latency: single sample into an empty FIFO, valid appears in the third cycle
        reset_a();
        a_mode = 0;
        send_a(32'h1111_0000, 1'b0, 16'd0, 16'd0, 1'b1);
        a_tvalid = 1'b0;
        @(negedge clk); chk("lat_cycle1", {31'd0, a_mvalid}, 32'd0);
        @(negedge clk); chk("lat_cycle2", {31'd0, a_mvalid}, 32'd0);
        @(negedge clk); chk("lat_cycle3", {31'd0, a_mvalid}, 32'd1);
        tick();
        drain_a();

        // Table-driven sequences under random output back-pressure
        a_mode = 2;
        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].rst) begin
                a_tvalid = 1'b0;
                drain_a();
                reset_a();
            end
            if (vt[i].gap > 0) begin
                a_tvalid = 1'b0;
                a_start = vt[i].idle_start;
                repeat (vt[i].gap) tick();
            end
            send_a(32'hA000_0000 + 32'(i), vt[i].start, vt[i].limit, vt[i].exp_cnt, vt[i].exp_last);
        end
        a_tvalid = 1'b0; a_start = 1'b0;
        drain_a();

        // Fill with output stalled: af threshold, capacity limit, then in-order drain
        reset_a();
        a_mode = 1;
        for (int i = 0; i < 15; i++)
            send_a(32'hF000_0000 + 32'(i), 1'b0, 16'd7, 16'(i % 8), (i % 8) == 7);
        a_tvalid = 1'b0;
        repeat (4) tick();
        @(negedge clk); chk("af_at_15", {31'd0, a_af}, 32'd0);
        tick();
        send_a(32'hF000_000F, 1'b0, 16'd7, 16'd7, 1'b1);
        a_tvalid = 1'b0;
        repeat (4) tick();
        @(negedge clk); chk("af_at_16", {31'd0, a_af}, 32'd1);
        tick();
        for (int i = 16; i < 32; i++)
            send_a(32'hF000_0000 + 32'(i), 1'b0, 16'd7, 16'(i % 8), (i % 8) == 7);
        a_tdata = 32'hF000_0020;
        repeat (6) begin
            @(negedge clk);
            chk("full_tready", {31'd0, a_tready}, 32'd0);
        end
        tick();
        a_tvalid = 1'b0;
        a_mode = 0;
        drain_a();
        repeat (3) tick();
        @(negedge clk);
        chk("af_after_drain", {31'd0, a_af}, 32'd0);
        chk("empty_after_drain", {31'd0, a_mvalid}, 32'd0);
        tick();

        // Reset mid-frame at count 5 discards everything; next sample restarts at 0
        reset_a();
        a_mode = 1;
        for (int i = 0; i < 6; i++)
            send_a(32'h6000_0000 + 32'(i), 1'b0, 16'd9, 16'(i), 1'b0);
        a_tvalid = 1'b0;
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        a_q.delete();
        @(negedge clk);
        chk("midrst_mvalid", {31'd0, a_mvalid}, 32'd0);
        chk("midrst_tready", {31'd0, a_tready}, 32'd1);
        tick();
        repeat (4) begin
            @(negedge clk);
            chk("midrst_flushed", {31'd0, a_mvalid}, 32'd0);
        end
        tick();
        a_mode = 0;
        send_a(32'h6100_0000, 1'b0, 16'd9, 16'd0, 1'b0);
        send_a(32'h6100_0001, 1'b0, 16'd9, 16'd1, 1'b0);
        a_tvalid = 1'b0;
        drain_a();

        // One-shot: three samples then halt; start alone does not re-arm
        reset_b();
        b_mode = 0;
        for (int i = 0; i < 3; i++)
            send_b(32'hB000_0000 + 32'(i), 1'b0, 4'd2, 16'(i), i == 2);
        repeat (5) begin
            @(negedge clk);
            chk("halt_tready", {31'd0, b_tready}, 32'd0);
        end
        tick();
        b_tvalid = 1'b0; b_start = 1'b1;
        tick();
        b_start = 1'b0; b_tvalid = 1'b1;
        @(negedge clk);
        chk("halt_start_alone", {31'd0, b_tready}, 32'd0);
        tick();
        send_b(32'hB000_0010, 1'b1, 4'd2, 16'd0, 1'b0);
        send_b(32'hB000_0011, 1'b0, 4'd2, 16'd1, 1'b0);
        b_tvalid = 1'b0; b_start = 1'b0;
        drain_b();

        // Full 4-bit cycle with random input gaps and output stalls
        reset_b();
        b_mode = 2;
        for (int i = 0; i < 16; i++) begin
            b_tvalid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            send_b(32'hC000_0000 + 32'(i), 1'b0, 4'd15, 16'(i), i == 15);
        end
        send_b(32'hC000_0010, 1'b1, 4'd15, 16'd0, 1'b0);
        for (int i = 1; i < 4; i++) begin
            b_tvalid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            send_b(32'hC000_0010 + 32'(i), 1'b0, 4'd15, 16'(i), 1'b0);
        end
        b_tvalid = 1'b0; b_start = 1'b0;
        b_mode = 0;
        drain_b();

        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_cycle_gen.md
Name: count_cycle_gen

Overview:
Parametrised successor to the 16-bit count/data aligner used in the channelizer datapath. It tags each accepted AXI-Stream sample with a CNT_WIDTH-bit cycle index and a final-count flag. It adds cycle-limit latching at frame start, a one-shot mode that halts after the final sample until re-armed, and an m_axis_tlast output. Tagged samples are buffered in an internal FIFO of parametrised depth with an almost-full indication.

Parameters:
DATA_WIDTH, 32, sample width in bits
CNT_WIDTH, 16, counter/limit width in bits (2..32)
FIFO_ADDR_WIDTH, 5, output FIFO depth = 2^FIFO_ADDR_WIDTH
AF_THRESH, 16, af asserted when FIFO occupancy >= AF_THRESH
ONE_SHOT, 0, 0 = free-running wrap; 1 = halt after final sample until start_sig

Ports:
clk  in  1  single clock, all logic rising-edge
sync_reset  in  1  synchronous reset, active-high
s_axis_tvalid  in  1  input sample valid
s_axis_tdata  in  DATA_WIDTH  input sample
s_axis_tready  out  1  input ready
cnt_limit  in  CNT_WIDTH  final index of a cycle (cycle length = cnt_limit+1), latched at frame start
start_sig  in  1  force count 0 on the sample accepted this cycle; re-arms in ONE_SHOT halt
af  out  1  FIFO almost full
m_axis_tvalid  out  1  output valid
m_axis_tdata  out  DATA_WIDTH  delayed sample
m_axis_count  out  CNT_WIDTH  index of this sample in its cycle
m_axis_tlast  out  1  1 when m_axis_count == latched limit
m_axis_tready  in  1  output ready

Behaviour:
- Interface: one clock, clk; reset sync_reset is synchronous and active-high.
- take = s_axis_tvalid & s_axis_tready & !sync_reset. Only taken samples are counted or stored.
- States: STARTUP (after reset), RUN, HALT (ONE_SHOT=1 only).
- STARTUP: the first taken sample gets count 0. Move to RUN.
- RUN: a taken sample gets count 0 if start_sig=1 or prev_count == lim_q. Otherwise it gets prev_count+1, modulo 2^CNT_WIDTH.
- lim_q is loaded from cnt_limit on every sample assigned count 0 and is held for the rest of the cycle. Changes to cnt_limit mid-cycle have no effect until the next count-0 sample.
- cnt_limit = 0: every sample gets count 0 and tlast=1. cnt_limit = all-ones: the full 2^CNT_WIDTH cycle length is used.
- Flag computation: tlast = (count == lim_q) evaluated with the lim_q in effect for that sample. A start_sig-forced count 0 with lim_q=0 gives tlast=1.
- ONE_SHOT=1: after a sample with tlast=1 is taken, enter HALT.
  - In HALT, s_axis_tready = start_sig & space_ok.
  - The sample taken in HALT gets count 0, lim_q reloads, and the state returns to RUN.
- s_axis_tready = !sync_reset & space_ok (& HALT gating above). space_ok = (FIFO occupancy + in-flight pipeline entries) < 2^FIFO_ADDR_WIDTH. The FIFO never overflows and no sample is dropped.
- Pipeline: two register stages carry {tlast, count, data} into the FIFO, so a sample is written 2 cycles after take.
- Latency: with the FIFO empty and m_axis_tready=1, m_axis_tvalid rises exactly 3 cycles after the take cycle. Throughput is one sample per clock sustained.
- Output handshake: standard AXI-Stream. tdata/count/tlast hold stable while tvalid=1 and tready=0. Order is preserved.
- Counting arithmetic may be pipelined, for example split into byte nibbles with a registered carry. The externally visible count sequence must still be exactly as above, including back-to-back takes, gaps, and start_sig on consecutive cycles.
- af = (occupancy >= AF_THRESH), registered and updated each cycle.
- Reset values (cycle after sync_reset sampled high): m_axis_tvalid=0, af=0, s_axis_tready=0 while sync_reset is high, state=STARTUP, FIFO empty, in-flight samples discarded, lim_q=0.
- s_axis_tready returns to 1 in the first cycle after sync_reset deasserts. Reset asserted mid-frame aborts the frame; the next sample is count 0.
- Simultaneous events: start_sig on a wrap sample gives count 0 (same result). start_sig while s_axis_tvalid=0 has no effect in RUN. In HALT, start_sig alone (no tvalid) does not leave HALT.

Test Plan:
- cnt_limit=3, continuous valid, tready=1, 10 samples D0..D9 -> counts 0,1,2,3,0,1,2,3,0,1; tlast on D3 and D7; first m_axis_tvalid 3 cycles after D0 taken.
- cnt_limit=5, start_sig pulsed with sample 3; cnt_limit changed to 1 at sample 2 -> counts 0,1,2,0,1,0,1; limit change applies only from sample 3; tlast on samples 4 and 6.
- ONE_SHOT=1, cnt_limit=2, valid held high -> 3 samples (0,1,2 with tlast on 2), then s_axis_tready=0 indefinitely; start_sig high for 1 cycle -> that sample is taken with count 0.
- FIFO_ADDR_WIDTH=5, AF_THRESH=16, m_axis_tready=0, valid continuous -> af asserts at occupancy 16; s_axis_tready drops so that exactly 32 samples are stored; tready=1 then drains all 32 in order with no loss.
- CNT_WIDTH=4, cnt_limit=15, 20 samples -> counts 0..15,0..3; tlast on sample 15; random tvalid/tready gaps give the identical sequence.
- sync_reset for 1 cycle mid-frame at count 5 (cnt_limit=9) -> FIFO empty, m_axis_tvalid=0 next cycle, the next sample taken gets count 0.
